xor_stream_accum: RTL and testbench

Parametrised streaming XOR accumulator. It folds a frame of WIDTH-bit words into a running bitwise XOR and reports the result once per frame. The report carries the XOR word, its reduction parity, a word count and an overflow flag. It sits beside the basic gate library as the first sequential XOR primitive, used for frame checksums and parity checks on datapaths, with valid/ready handshakes on both sides.

---
 rtl/xor_stream_accum.sv | 104 ++++++++++
 tb/tb_xor_stream_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_accum.sv
// Streaming XOR accumulator: folds a frame of words into a running XOR
// and reports sum, parity, saturating word count and overflow per frame.
module xor_stream_accum #(
    parameter int                 WIDTH     = 8,
    parameter int                 MAX_WORDS = 16,
    parameter logic [WIDTH-1:0]   INIT      = {WIDTH{1'b0}},
    localparam int                CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
);

    typedef enum logic {ACC, DONE} state_t;

    localparam logic [CW-1:0] MAXC = CW'(MAX_WORDS);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_parity_q;
    logic [CW-1:0]    out_count_q;
    logic             out_ovf_q;
    logic             accept;

    assign in_ready = (state_q == ACC) & ~rst;
    assign accept   = in_valid & in_ready;

    // Next values for an accepted word; the count sticks at MAX_WORDS.
    always_comb begin
        acc_d = acc_q ^ in_data;
        cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
        ovf_d = ovf_q | (cnt_q == MAXC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACC;
            acc_q        <= INIT;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
        end else if (clear) begin
            state_q     <= ACC;
            acc_q       <= INIT;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            out_sum_q    <= acc_d;
                            out_parity_q <= ^acc_d;
                            out_count_q  <= cnt_d;
                            out_ovf_q    <= ovf_d;
                            out_valid_q  <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            ovf_q <= ovf_d;
                        end
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= INIT;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_parity = out_parity_q;
    assign out_count  = out_count_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_xor_stream_accum.sv
// Scoreboard bench for xor_stream_accum: directed scenarios plus random
// frames checked against a frame-level reference model.
module tb_xor_stream_accum;

    localparam int W  = 8;
    localparam int MW = 4;
    localparam int CW = $clog2(MW + 1);

    typedef struct {
        logic [W-1:0]  sum;
        logic          par;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_parity;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    logic [W-1:0] frame[$];
    exp_t         expq[$];

    xor_stream_accum #(.WIDTH(W), .MAX_WORDS(MW), .INIT(8'h00)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_parity(out_parity),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result for a complete frame held in 'frame'.
    function automatic exp_t model_frame();
        exp_t e;
        e.sum = 8'h00;
        foreach (frame[i]) e.sum = e.sum ^ frame[i];
        e.par = 1'b0;
        for (int b = 0; b < W; b++) e.par = e.par ^ e.sum[b];
        e.cnt = (frame.size() > MW) ? CW'(MW) : CW'(frame.size());
        e.ovf = frame.size() > MW;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int  n;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got 0 expected 1");
        end else begin
            frame.push_back(d);
            if (l) begin
                expq.push_back(model_frame());
                frame.delete();
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len);
        for (int i = 0; i < len; i++) begin
            send_word(W'($urandom), i == len - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    // Monitor: compare every delivered result against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got sum %0h expected none",
                             out_sum);
                end else begin
                    e = expq.pop_front();
                    check("out_sum", 32'(out_sum), 32'(e.sum));
                    check("out_parity", 32'(out_parity), 32'(e.par));
                    check("out_count", 32'(out_count), 32'(e.cnt));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_count", 32'(out_count), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);

        // basic frame with latency and bubble
        out_ready = 1'b1;
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        send_word(8'h56, 1'b1);
        check("basic_valid_next", 32'(out_valid), 1);
        check("basic_ready_low", 32'(in_ready), 0);
        check("basic_sum_0x70", 32'(out_sum), 32'h70);
        idle(1);
        check("basic_ready_back", 32'(in_ready), 1);
        check("basic_valid_drop", 32'(out_valid), 0);

        // single word frame
        send_word(8'hA5, 1'b1);
        idle(1);

        // backpressure
        out_ready = 1'b0;
        send_word(8'hFF, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", 32'(out_valid), 1);
            check("bp_sum_hold", 32'(out_sum), 32'hFF);
            check("bp_in_ready_low", 32'(in_ready), 0);
            idle(1);
        end
        out_ready = 1'b1;
        send_word(8'h11, 1'b1);
        idle(1);

        // overflow: six words of 0x01
        for (int i = 0; i < 6; i++) send_word(8'h01, i == 5);
        idle(1);
        send_word(8'h03, 1'b1);
        idle(1);

        // clear mid-frame drops the partial frame and the presented word
        send_word(8'hAA, 1'b0);
        send_word(8'h55, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'b1;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        frame.delete();
        check("clear_no_valid", 32'(out_valid), 0);
        send_word(8'h0F, 1'b1);
        idle(1);

        // async reset between edges
        send_word(8'h77, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_sum", 32'(out_sum), 0);
        check("arst_out_count", 32'(out_count), 0);
        check("arst_out_parity", 32'(out_parity), 0);
        frame.delete();
        expq.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'h3C, 1'b1);
        idle(1);

        // random frames with random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 150; f++) begin
            send_frame($urandom_range(1, 7));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        idle(10);
        check("drain_empty", 32'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
